// File: rtl/mips_lite_pkg.sv
// Shared encodings for the MIPS-lite control path: opcodes, functs,
// ALU control codes, sequencer states and instruction classes.
package mips_lite_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_NORI   = 6'b010011;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BLEZAL = 6'b011110;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_JMXOR = 6'b100110;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_BRV = 4'b1000;
    localparam logic [3:0] ALU_XOR = 4'b1001;
    localparam logic [3:0] ALU_NOR = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE   = 3'd0,
        CLS_NORI    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BEQ     = 3'd4,
        CLS_BLEZAL  = 3'd5,
        CLS_ILLEGAL = 3'd6
    } instr_class_e;

    function automatic logic is_mem_class(input instr_class_e cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE);
    endfunction

endpackage

// File: rtl/alu_op_sequencer_decode.sv
// Combinational opcode/funct decoder shared by the multicycle sequencer
// and the single-cycle path.
module alu_ctrl_decode
    import mips_lite_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output logic [3:0]   alu_ctrl,
    output instr_class_e cls,
    output logic         alusrc,
    output logic         regdst
);

    // Table lookup; anything not listed falls through as illegal.
    always_comb begin
        alu_ctrl = ALU_ADD;
        cls      = CLS_ILLEGAL;
        alusrc   = 1'b0;
        regdst   = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD:   begin alu_ctrl = ALU_ADD; cls = CLS_RTYPE; regdst = 1'b1; end
                    FN_SUB:   begin alu_ctrl = ALU_SUB; cls = CLS_RTYPE; regdst = 1'b1; end
                    FN_AND:   begin alu_ctrl = ALU_AND; cls = CLS_RTYPE; regdst = 1'b1; end
                    FN_OR:    begin alu_ctrl = ALU_OR;  cls = CLS_RTYPE; regdst = 1'b1; end
                    FN_SLT:   begin alu_ctrl = ALU_SLT; cls = CLS_RTYPE; regdst = 1'b1; end
                    FN_JMXOR: begin alu_ctrl = ALU_XOR; cls = CLS_RTYPE; regdst = 1'b1; end
                    default:  begin cls = CLS_ILLEGAL; end
                endcase
            end
            OP_NORI:   begin alu_ctrl = ALU_NOR; cls = CLS_NORI;   alusrc = 1'b1; end
            OP_LW:     begin alu_ctrl = ALU_ADD; cls = CLS_LOAD;   alusrc = 1'b1; end
            OP_SW:     begin alu_ctrl = ALU_ADD; cls = CLS_STORE;  alusrc = 1'b1; end
            OP_BEQ:    begin alu_ctrl = ALU_SUB; cls = CLS_BEQ;    end
            OP_BLEZAL: begin alu_ctrl = ALU_BRV; cls = CLS_BLEZAL; end
            default:   begin cls = CLS_ILLEGAL; end
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle MIPS-lite control sequencer: accepts one instruction, walks
// DECODE/EXEC/MEM/WB and drives registered ALU control and commit strobes.
module alu_op_sequencer
    import mips_lite_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        alu_zout,
    input  logic        alu_sum_msb,
    output logic [3:0]  alu_ctrl,
    output logic        alusrc,
    output logic        regdst,
    output logic        regwrite,
    output logic        link,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        pcsrc,
    output logic        illegal,
    output logic        busy
);

    state_e       state_q, state_d;
    instr_class_e cls_q, cls_d, dec_cls_s;
    logic [5:0]   op_q, op_d, fn_q, fn_d, dec_op_s, dec_fn_s;
    logic [3:0]   alu_ctrl_q, alu_ctrl_d, dec_alu_s;
    logic         alusrc_q, alusrc_d, regdst_q, regdst_d, dec_alusrc_s, dec_regdst_s;
    logic         regwrite_q, regwrite_d, link_q, link_d, memread_q, memread_d;
    logic         memwrite_q, memwrite_d, memtoreg_q, memtoreg_d;
    logic         pcsrc_q, pcsrc_d, illegal_q, illegal_d;
    logic         taken_s;
    logic         unused_instr_s;

    // In IDLE the raw word is decoded so an illegal pulse can line up with DECODE.
    assign dec_op_s       = (state_q == ST_IDLE) ? instr[31:26] : op_q;
    assign dec_fn_s       = (state_q == ST_IDLE) ? instr[5:0]   : fn_q;
    assign unused_instr_s = ^instr[25:6];
    assign taken_s        = (cls_q == CLS_BEQ) ? alu_zout : (alu_zout | alu_sum_msb);

    alu_ctrl_decode u_decode (
        .opcode   (dec_op_s),
        .funct    (dec_fn_s),
        .alu_ctrl (dec_alu_s),
        .cls      (dec_cls_s),
        .alusrc   (dec_alusrc_s),
        .regdst   (dec_regdst_s)
    );

    // Next-state, instruction latch and next values of all registered outputs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        fn_d       = fn_q;
        cls_d      = cls_q;
        alu_ctrl_d = ALU_ADD;
        alusrc_d   = 1'b0;
        regdst_d   = regdst_q;
        regwrite_d = 1'b0;
        link_d     = 1'b0;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        memtoreg_d = 1'b0;
        pcsrc_d    = 1'b0;
        illegal_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                regdst_d = 1'b0;
                if (instr_valid) begin
                    op_d      = instr[31:26];
                    fn_d      = instr[5:0];
                    state_d   = ST_DECODE;
                    illegal_d = (dec_cls_s == CLS_ILLEGAL);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DECODE: begin
                if (dec_cls_s == CLS_ILLEGAL) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d    = ST_EXEC;
                    cls_d      = dec_cls_s;
                    alu_ctrl_d = dec_alu_s;
                    alusrc_d   = dec_alusrc_s;
                    regdst_d   = dec_regdst_s;
                end
            end
            ST_EXEC: begin
                // Flags are consumed on this edge; branch outcome goes straight into the strobes.
                if (is_mem_class(cls_q)) begin
                    state_d    = ST_MEM;
                    alu_ctrl_d = alu_ctrl_q;
                    alusrc_d   = alusrc_q;
                end else begin
                    state_d = ST_WB;
                end
                case (cls_q)
                    CLS_LOAD:            memread_d  = 1'b1;
                    CLS_STORE:           memwrite_d = 1'b1;
                    CLS_RTYPE, CLS_NORI: regwrite_d = 1'b1;
                    CLS_BEQ:             pcsrc_d    = taken_s;
                    CLS_BLEZAL: begin
                        pcsrc_d    = taken_s;
                        link_d     = taken_s;
                        regwrite_d = taken_s;
                    end
                    default:             state_d    = ST_IDLE;
                endcase
            end
            ST_MEM: begin
                if (cls_q == CLS_LOAD) begin
                    state_d    = ST_WB;
                    regwrite_d = 1'b1;
                    memtoreg_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                state_d  = ST_IDLE;
                regdst_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                regdst_d = 1'b0;
            end
        endcase
    end

    // State, instruction fields and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 6'd0;
            fn_q       <= 6'd0;
            cls_q      <= CLS_ILLEGAL;
            alu_ctrl_q <= ALU_ADD;
            alusrc_q   <= 1'b0;
            regdst_q   <= 1'b0;
            regwrite_q <= 1'b0;
            link_q     <= 1'b0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            pcsrc_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            fn_q       <= fn_d;
            cls_q      <= cls_d;
            alu_ctrl_q <= alu_ctrl_d;
            alusrc_q   <= alusrc_d;
            regdst_q   <= regdst_d;
            regwrite_q <= regwrite_d;
            link_q     <= link_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            memtoreg_q <= memtoreg_d;
            pcsrc_q    <= pcsrc_d;
            illegal_q  <= illegal_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign alu_ctrl    = alu_ctrl_q;
    assign alusrc      = alusrc_q;
    assign regdst      = regdst_q;
    assign regwrite    = regwrite_q;
    assign link        = link_q;
    assign memread     = memread_q;
    assign memwrite    = memwrite_q;
    assign memtoreg    = memtoreg_q;
    assign pcsrc       = pcsrc_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer; cycle 0 is the accept
// cycle and outputs are sampled 1 time unit after each rising edge.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid, instr_ready, alu_zout, alu_sum_msb;
    logic [3:0]  alu_ctrl;
    logic        alusrc, regdst, regwrite, link, memread, memwrite, memtoreg, pcsrc, illegal, busy;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_zout(alu_zout), .alu_sum_msb(alu_sum_msb),
        .alu_ctrl(alu_ctrl), .alusrc(alusrc), .regdst(regdst), .regwrite(regwrite),
        .link(link), .memread(memread), .memwrite(memwrite), .memtoreg(memtoreg),
        .pcsrc(pcsrc), .illegal(illegal), .busy(busy)
    );

    // Observed vector: {alu_ctrl, alusrc, regdst, regwrite, link, memread, memwrite, memtoreg, pcsrc, illegal, busy, instr_ready}
    function automatic logic [14:0] obs_f();
        return {alu_ctrl, alusrc, regdst, regwrite, link, memread, memwrite, memtoreg, pcsrc, illegal, busy, instr_ready};
    endfunction

    // Expected vector builder; strobes are {regwrite, link, memread, memwrite, memtoreg, pcsrc, illegal}
    function automatic logic [14:0] ev(input logic [3:0] a, input logic s, input logic d, input logic [6:0] st, input logic b);
        return {a, s, d, st, b, ~b};
    endfunction

    localparam logic [14:0] IDLE_V = {4'b0010, 1'b0, 1'b0, 7'b0000000, 1'b0, 1'b1};

    task automatic issue(input logic [31:0] w);
        int n;
        n = 0;
        @(negedge clk);
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready_timeout act=%b exp=1", instr_ready);
        end
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
        instr = 32'hDEADBEEF;
    endtask

    task automatic test_reset();
        logic [14:0] exp [1:2];
        checks++;
        if (obs_f() !== IDLE_V) begin
            errors++;
            $display("FAIL reset_state act=%b exp=%b", obs_f(), IDLE_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp[1] = ev(4'b0010, 1'b0, 1'b0, 7'b0, 1'b1);
        exp[2] = ev(4'b0010, 1'b1, 1'b0, 7'b0, 1'b1);
        issue(32'h8C220004);
        for (int c = 1; c <= 2; c++) begin
            checks++;
            if (obs_f() !== exp[c]) begin
                errors++;
                $display("FAIL rst_lw_c%0d act=%b exp=%b", c, obs_f(), exp[c]);
            end
            if (c < 2) begin
                @(posedge clk);
                #1;
            end
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs_f() !== IDLE_V) begin
            errors++;
            $display("FAIL rst_async act=%b exp=%b", obs_f(), IDLE_V);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (obs_f() !== IDLE_V) begin
                errors++;
                $display("FAIL rst_release_c%0d act=%b exp=%b", c, obs_f(), IDLE_V);
            end
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] ops  [5];
        logic [3:0]  alus [5];
        logic        srcs [5];
        logic        dsts [5];
        logic [14:0] exp  [1:4];
        ops[0] = 32'h00221820; alus[0] = 4'b0010; srcs[0] = 1'b0; dsts[0] = 1'b1;
        ops[1] = 32'h00221822; alus[1] = 4'b0110; srcs[1] = 1'b0; dsts[1] = 1'b1;
        ops[2] = 32'h00221826; alus[2] = 4'b1001; srcs[2] = 1'b0; dsts[2] = 1'b1;
        ops[3] = 32'h0022182A; alus[3] = 4'b0111; srcs[3] = 1'b0; dsts[3] = 1'b1;
        ops[4] = 32'h4C2200FF; alus[4] = 4'b1010; srcs[4] = 1'b1; dsts[4] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp[1] = ev(4'b0010, 1'b0, 1'b0, 7'b0, 1'b1);
            exp[2] = ev(alus[i], srcs[i], dsts[i], 7'b0, 1'b1);
            exp[3] = ev(4'b0010, 1'b0, dsts[i], 7'b1000000, 1'b1);
            exp[4] = IDLE_V;
            issue(ops[i]);
            for (int c = 1; c <= 4; c++) begin
                checks++;
                if (obs_f() !== exp[c]) begin
                    errors++;
                    $display("FAIL alu_op%0d_c%0d act=%b exp=%b", i, c, obs_f(), exp[c]);
                end
                if (c < 4) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [1:9];
        exp[1] = ev(4'b0010, 1'b0, 1'b0, 7'b0, 1'b1);
        exp[2] = ev(4'b0010, 1'b1, 1'b0, 7'b0, 1'b1);
        exp[3] = ev(4'b0010, 1'b1, 1'b0, 7'b0010000, 1'b1);
        exp[4] = ev(4'b0010, 1'b0, 1'b0, 7'b1000100, 1'b1);
        exp[5] = IDLE_V;
        exp[6] = ev(4'b0010, 1'b0, 1'b0, 7'b0, 1'b1);
        exp[7] = ev(4'b0010, 1'b1, 1'b0, 7'b0, 1'b1);
        exp[8] = ev(4'b0010, 1'b1, 1'b0, 7'b0001000, 1'b1);
        exp[9] = IDLE_V;
        @(negedge clk);
        instr = 32'h8C220004;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        instr = 32'hAC220008;
        for (int c = 1; c <= 9; c++) begin
            checks++;
            if (obs_f() !== exp[c]) begin
                errors++;
                $display("FAIL b2b_c%0d act=%b exp=%b", c, obs_f(), exp[c]);
            end
            if (c == 8) instr_valid = 1'b0;
            if (c < 9) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] ops  [5];
        logic [3:0]  alus [5];
        logic        zs   [5];
        logic        ms   [5];
        logic [6:0]  wbs  [5];
        logic [14:0] exp  [1:4];
        ops[0] = 32'h10220003; alus[0] = 4'b0110; zs[0] = 1'b1; ms[0] = 1'b0; wbs[0] = 7'b0000010;
        ops[1] = 32'h10220003; alus[1] = 4'b0110; zs[1] = 1'b0; ms[1] = 1'b1; wbs[1] = 7'b0000000;
        ops[2] = 32'h78200010; alus[2] = 4'b1000; zs[2] = 1'b0; ms[2] = 1'b1; wbs[2] = 7'b1100010;
        ops[3] = 32'h78200010; alus[3] = 4'b1000; zs[3] = 1'b0; ms[3] = 1'b0; wbs[3] = 7'b0000000;
        ops[4] = 32'h78200010; alus[4] = 4'b1000; zs[4] = 1'b1; ms[4] = 1'b0; wbs[4] = 7'b1100010;
        for (int i = 0; i < 5; i++) begin
            alu_zout = zs[i];
            alu_sum_msb = ms[i];
            exp[1] = ev(4'b0010, 1'b0, 1'b0, 7'b0, 1'b1);
            exp[2] = ev(alus[i], 1'b0, 1'b0, 7'b0, 1'b1);
            exp[3] = ev(4'b0010, 1'b0, 1'b0, wbs[i], 1'b1);
            exp[4] = IDLE_V;
            issue(ops[i]);
            for (int c = 1; c <= 4; c++) begin
                checks++;
                if (obs_f() !== exp[c]) begin
                    errors++;
                    $display("FAIL branch%0d_c%0d act=%b exp=%b", i, c, obs_f(), exp[c]);
                end
                if (c < 4) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        alu_zout = 1'b0;
        alu_sum_msb = 1'b0;
    endtask

    task automatic test_illegal();
        logic [31:0] ops [2];
        logic [14:0] exp [1:3];
        ops[0] = 32'hFC000000;
        ops[1] = 32'h0000003F;
        exp[1] = ev(4'b0010, 1'b0, 1'b0, 7'b0000001, 1'b1);
        exp[2] = IDLE_V;
        exp[3] = IDLE_V;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i]);
            for (int c = 1; c <= 3; c++) begin
                checks++;
                if (obs_f() !== exp[c]) begin
                    errors++;
                    $display("FAIL illegal%0d_c%0d act=%b exp=%b", i, c, obs_f(), exp[c]);
                end
                if (c < 3) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        instr_valid = 1'b0;
        alu_zout = 1'b0;
        alu_sum_msb = 1'b0;
        #12;
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_branch();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
